// File: rtl/sync_fifo_flags.sv
// rtl/sync_fifo_flags.sv - single-clock FIFO, any depth, programmable almost flags, sticky errors
// Define SYNC_FIFO_FWFT_EN for first-word-fall-through reads; default is registered 1-cycle reads.
module sync_fifo_flags #(
  parameter int DATA_WIDTH = 16,
  parameter int DEPTH      = 1000,
  parameter int CNT_WIDTH  = $clog2(DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] din,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] dout,
  output logic                  dout_valid,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic [CNT_WIDTH-1:0]  count,
  input  logic [CNT_WIDTH-1:0]  af_level,
  input  logic [CNT_WIDTH-1:0]  ae_level,
  input  logic                  clear_err,
  output logic                  overflow,
  output logic                  underflow
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PTR_W-1:0]     PTR_LAST = PTR_W'(DEPTH - 1);
  localparam logic [CNT_WIDTH-1:0] DEPTH_C  = CNT_WIDTH'(DEPTH);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0]      wr_ptr;
  logic [PTR_W-1:0]      rd_ptr;
  logic                  rd_acc;
  logic                  wr_acc;
  logic [DATA_WIDTH-1:0] rd_word;

  // Unknown bits from never-written storage are forced to 0 so dout is always clean.
  function automatic logic [DATA_WIDTH-1:0] scrub(input logic [DATA_WIDTH-1:0] w);
    for (int i = 0; i < DATA_WIDTH; i++) begin
      scrub[i] = (w[i] === 1'b1);
    end
  endfunction

  assign empty        = (count == '0);
  assign full         = (count == DEPTH_C);
  assign almost_full  = (count >= af_level);
  assign almost_empty = (count <= ae_level);

  assign rd_acc  = rd_en & ~empty;
  assign wr_acc  = wr_en & (~full | rd_acc);
  assign rd_word = scrub(mem[rd_ptr]);

  always_ff @(posedge clk) begin
    if (wr_acc) begin
      mem[wr_ptr] <= din;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (wr_acc) begin
        wr_ptr <= (wr_ptr == PTR_LAST) ? '0 : wr_ptr + PTR_W'(1);
      end
      if (rd_acc) begin
        rd_ptr <= (rd_ptr == PTR_LAST) ? '0 : rd_ptr + PTR_W'(1);
      end
      case ({wr_acc, rd_acc})
        2'b10:   count <= count + CNT_WIDTH'(1);
        2'b01:   count <= count - CNT_WIDTH'(1);
        default: count <= count;
      endcase
      // A new error in the same cycle as clear_err wins.
      overflow  <= (overflow  & ~clear_err) | (wr_en & ~wr_acc);
      underflow <= (underflow & ~clear_err) | (rd_en & ~rd_acc);
    end
  end

`ifdef SYNC_FIFO_FWFT_EN
  assign dout       = rd_word;
  assign dout_valid = ~empty;
`else
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      dout       <= '0;
      dout_valid <= 1'b0;
    end else begin
      dout_valid <= rd_acc;
      if (rd_acc) begin
        dout <= rd_word;
      end
    end
  end
`endif

  af_level_legal: assert property (@(posedge clk) disable iff (!reset_n)
    (af_level >= CNT_WIDTH'(1)) && (af_level <= DEPTH_C));
  ae_level_legal: assert property (@(posedge clk) disable iff (!reset_n)
    ae_level < DEPTH_C);

endmodule

// File: tb/tb_sync_fifo_flags.sv
// tb/tb_sync_fifo_flags.sv - scoreboard bench for sync_fifo_flags with a queue reference model
module tb_sync_fifo_flags;
  localparam int DW = 8;
  localparam int DP = 5;
  localparam int CW = $clog2(DP + 1);

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          wr_en = 1'b0;
  logic [DW-1:0] din = '0;
  logic          rd_en = 1'b0;
  logic [DW-1:0] dout;
  logic          dout_valid;
  logic          full, empty, almost_full, almost_empty;
  logic [CW-1:0] count;
  logic [CW-1:0] af_level = CW'(4);
  logic [CW-1:0] ae_level = CW'(1);
  logic          clear_err = 1'b0;
  logic          overflow, underflow;

  sync_fifo_flags #(.DATA_WIDTH(DW), .DEPTH(DP)) dut (
    .clk(clk), .reset_n(reset_n), .wr_en(wr_en), .din(din), .rd_en(rd_en),
    .dout(dout), .dout_valid(dout_valid), .full(full), .empty(empty),
    .almost_full(almost_full), .almost_empty(almost_empty), .count(count),
    .af_level(af_level), .ae_level(ae_level), .clear_err(clear_err),
    .overflow(overflow), .underflow(underflow)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [DW-1:0] model_q[$];
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] last_dout = '0;
  bit            m_ovf = 0;
  bit            m_udf = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
    end
  endtask

  task automatic model_reset();
    model_q.delete();
    exp_q.delete();
    last_dout = '0;
    m_ovf = 0;
    m_udf = 0;
  endtask

  // Drives one cycle of stimulus; called just after a rising edge.
  task automatic cycle(input bit w, input logic [DW-1:0] d, input bit r, input bit c);
    bit rd_ok, wr_ok;
    logic [DW-1:0] v;
    wr_en = w; din = d; rd_en = r; clear_err = c;
    rd_ok = r && (model_q.size() > 0);
    wr_ok = w && ((model_q.size() < DP) || rd_ok);
    @(posedge clk);
    #1;
    if (rd_ok) begin
      v = model_q.pop_front();
      exp_q.push_back(v);
    end
    if (wr_ok) model_q.push_back(d);
    m_ovf = (m_ovf && !c) || (w && !wr_ok);
    m_udf = (m_udf && !c) || (r && !rd_ok);
    wr_en = 0; rd_en = 0; clear_err = 0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(0, '0, 0, 0);
  endtask

  // Monitor: compares DUT outputs with the model away from the active edge.
  always @(negedge clk) begin
    if (reset_n) begin
`ifdef SYNC_FIFO_FWFT_EN
      exp_q.delete();
      chk("dout_valid", int'(dout_valid), int'(model_q.size() != 0));
      if (model_q.size() != 0) chk("dout", int'(dout), int'(model_q[0]));
`else
      if (exp_q.size() > 0) begin
        last_dout = exp_q.pop_front();
        chk("dout_valid", int'(dout_valid), 1);
        chk("dout", int'(dout), int'(last_dout));
      end else begin
        chk("dout_valid", int'(dout_valid), 0);
        chk("dout_hold", int'(dout), int'(last_dout));
      end
`endif
      chk("count", int'(count), model_q.size());
      chk("empty", int'(empty), int'(model_q.size() == 0));
      chk("full", int'(full), int'(model_q.size() == DP));
      chk("almost_full", int'(almost_full), int'(model_q.size() >= int'(af_level)));
      chk("almost_empty", int'(almost_empty), int'(model_q.size() <= int'(ae_level)));
      chk("overflow", int'(overflow), int'(m_ovf));
      chk("underflow", int'(underflow), int'(m_udf));
    end
  end

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_count"}, int'(count), 0);
    chk({tag, "_empty"}, int'(empty), 1);
    chk({tag, "_full"}, int'(full), 0);
    chk({tag, "_ae"}, int'(almost_empty), 1);
    chk({tag, "_af"}, int'(almost_full), 0);
    chk({tag, "_ovf"}, int'(overflow), 0);
    chk({tag, "_udf"}, int'(underflow), 0);
`ifndef SYNC_FIFO_FWFT_EN
    chk({tag, "_dout"}, int'(dout), 0);
    chk({tag, "_dout_valid"}, int'(dout_valid), 0);
`endif
  endtask

  initial begin
    model_reset();
    #2;
    check_reset_outputs("reset");
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    idle(1);

    // Fill to full, then one rejected write.
    for (int i = 1; i <= DP; i++) cycle(1, DW'(8'h11 * i), 0, 0);
    cycle(1, 8'h66, 0, 0);
    // Drain in order, then one rejected read.
    for (int i = 0; i < DP; i++) cycle(0, '0, 1, 0);
    cycle(0, '0, 1, 0);
    cycle(0, '0, 0, 1);

    // Pointer wrap.
    for (int i = 0; i < 3; i++) cycle(1, DW'(8'h30 + i), 0, 0);
    for (int i = 0; i < 3; i++) cycle(0, '0, 1, 0);
    for (int i = 0; i < DP; i++) cycle(1, DW'(8'hA0 + i), 0, 0);
    for (int i = 0; i < DP; i++) cycle(0, '0, 1, 0);

    // Simultaneous write and read while full.
    for (int i = 0; i < DP; i++) cycle(1, DW'(8'hC0 + i), 0, 0);
    cycle(1, 8'h77, 1, 0);
    for (int i = 0; i < DP; i++) cycle(0, '0, 1, 0);
    idle(1);

    // Simultaneous write and read while empty, then clear_err racing a new error.
    cycle(1, 8'h5A, 1, 0);
    cycle(0, '0, 0, 1);
    cycle(0, '0, 1, 0);
    cycle(0, '0, 1, 1);
    cycle(0, '0, 0, 1);

    // Randomised traffic with moving thresholds.
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 15) == 0) begin
        af_level = CW'($urandom_range(1, DP));
        ae_level = CW'($urandom_range(0, DP - 1));
      end
      cycle(bit'($urandom_range(0, 1)), DW'($urandom_range(0, 255)),
            bit'($urandom_range(0, 1)), $urandom_range(0, 9) == 0);
    end
    idle(2);

    // Asynchronous reset mid-fill, checked between edges.
    af_level = CW'(4);
    ae_level = CW'(1);
    for (int i = 0; i < 3; i++) cycle(1, DW'(8'hE0 + i), 0, 0);
    cycle(0, '0, 1, 0);
    #1;
    reset_n = 1'b0;
    #1;
    model_reset();
    check_reset_outputs("async_reset");
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    cycle(1, 8'h99, 0, 0);
    cycle(0, '0, 1, 0);
    idle(2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, got running expected done");
    $fatal(1, "timeout");
  end

endmodule
